// File: rtl/med_pkg.sv
// Shared constants and types for the streaming 3x3 median filter.
package med_pkg;

  localparam int MED_LAT = 3;
  localparam int PIX_W   = 8;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Window at the default pixel width: 3 columns of 3 rows, oldest column in [2:0].
  typedef logic [8:0][PIX_W-1:0] win_t;

endpackage

// File: rtl/med9_pipe.sv
// Three-stage 9-input median network: sort each column, reduce to max/med/min,
// then take the median of those three. Every register advances only on en.
module med9_pipe
  import med_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [8:0][WIDTH-1:0] in_win,
  input  logic                  in_sof,
  input  logic                  in_eol,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_sof,
  output logic                  out_eol
);

  typedef logic [WIDTH-1:0] pix_t;

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  pix_t [2:0]         lo_d, lo_q, mid_d, mid_q, hi_d, hi_q;
  pix_t               mx_d, mx_q, md_d, md_q, mn_d, mn_q;
  pix_t               out_d, out_q;
  logic [MED_LAT-1:0] v_d, v_q, sof_d, sof_q, eol_d, eol_q;

  always_comb begin
    for (int g = 0; g < 3; g++) begin
      lo_d[g]  = min2(min2(in_win[3*g], in_win[3*g+1]), in_win[3*g+2]);
      hi_d[g]  = max2(max2(in_win[3*g], in_win[3*g+1]), in_win[3*g+2]);
      mid_d[g] = med3(in_win[3*g], in_win[3*g+1], in_win[3*g+2]);
    end
    // The median of nine is bounded by max-of-lows, med-of-mids and min-of-highs.
    mx_d  = max2(max2(lo_q[0], lo_q[1]), lo_q[2]);
    md_d  = med3(mid_q[0], mid_q[1], mid_q[2]);
    mn_d  = min2(min2(hi_q[0], hi_q[1]), hi_q[2]);
    out_d = med3(mx_q, md_q, mn_q);
    v_d   = {v_q[MED_LAT-2:0], in_valid};
    sof_d = {sof_q[MED_LAT-2:0], in_sof};
    eol_d = {eol_q[MED_LAT-2:0], in_eol};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q  <= '0;
      mid_q <= '0;
      hi_q  <= '0;
      mx_q  <= '0;
      md_q  <= '0;
      mn_q  <= '0;
      out_q <= '0;
      v_q   <= '0;
      sof_q <= '0;
      eol_q <= '0;
    end else if (en) begin
      lo_q  <= lo_d;
      mid_q <= mid_d;
      hi_q  <= hi_d;
      mx_q  <= mx_d;
      md_q  <= md_d;
      mn_q  <= mn_d;
      out_q <= out_d;
      v_q   <= v_d;
      sof_q <= sof_d;
      eol_q <= eol_d;
    end
  end

  assign out_valid = v_q[MED_LAT-1];
  assign out_data  = out_q;
  assign out_sof   = sof_q[MED_LAT-1];
  assign out_eol   = eol_q[MED_LAT-1];

endmodule

// File: rtl/med_stream_3x3.sv
// Streaming 3x3 median filter over a raster; emits interior pixels only.
// One global enable stalls the whole datapath under output backpressure.
module med_stream_3x3
  import med_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COLS  = 512,
  parameter int ROWS  = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_sof,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             sof_err
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [CW-1:0]         col_d, col_q, eff_col;
  logic [RW-1:0]         row_d, row_q, eff_row;
  state_e                state_d, state_q, eff_st;
  logic [8:0][WIDTH-1:0] win_d, win_q;
  logic                  win_v_d, win_v_q, win_sof_d, win_sof_q, win_eol_d, win_eol_q;
  logic                  sof_err_d, sof_err_q;
  logic                  en, acc, sof_force;
  logic [WIDTH-1:0]      rd0, rd1;

  logic [WIDTH-1:0] lb0_q [COLS];
  logic [WIDTH-1:0] lb1_q [COLS];

  assign en        = !m_valid || m_ready;
  assign s_ready   = en;
  assign acc       = s_valid && en;
  // A start-of-frame anywhere but the origin restarts the raster at this pixel.
  assign sof_force = s_sof && ((col_q != '0) || (row_q != '0));
  assign eff_col   = sof_force ? '0 : col_q;
  assign eff_row   = sof_force ? '0 : row_q;
  assign eff_st    = sof_force ? ST_FILL : state_q;
  assign rd0       = lb0_q[eff_col];
  assign rd1       = lb1_q[eff_col];

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    state_d   = state_q;
    win_d     = win_q;
    win_v_d   = win_v_q;
    win_sof_d = win_sof_q;
    win_eol_d = win_eol_q;
    sof_err_d = 1'b0;
    if (en) begin
      win_v_d   = 1'b0;
      win_sof_d = 1'b0;
      win_eol_d = 1'b0;
    end
    if (acc) begin
      // Newest column enters at the top: [6]=two lines up, [7]=one line up, [8]=current.
      win_d     = {s_data, rd0, rd1, win_q[8:3]};
      win_v_d   = (eff_st == ST_STREAM) && (eff_col >= CW'(2));
      win_sof_d = win_v_d && (eff_row == RW'(2)) && (eff_col == CW'(2));
      win_eol_d = win_v_d && (eff_col == CW'(COLS - 1));
      sof_err_d = sof_force;
      row_d     = eff_row;
      if (eff_col == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = (eff_row == RW'(ROWS - 1)) ? '0 : eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
      end
      state_d = (row_d >= RW'(2)) ? ST_STREAM : ST_FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      state_q   <= ST_FILL;
      win_q     <= '0;
      win_v_q   <= 1'b0;
      win_sof_q <= 1'b0;
      win_eol_q <= 1'b0;
      sof_err_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      state_q   <= state_d;
      win_q     <= win_d;
      win_v_q   <= win_v_d;
      win_sof_q <= win_sof_d;
      win_eol_q <= win_eol_d;
      sof_err_q <= sof_err_d;
    end
  end

  // Line buffers hold no reset; FILL rewrites every entry before it is read.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0_q[eff_col] <= s_data;
      lb1_q[eff_col] <= rd0;
    end
  end

  med9_pipe #(
    .WIDTH(WIDTH)
  ) u_med (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (win_v_q),
    .in_win   (win_q),
    .in_sof   (win_sof_q),
    .in_eol   (win_eol_q),
    .out_valid(m_valid),
    .out_data (m_data),
    .out_sof  (m_sof),
    .out_eol  (m_eol)
  );

  assign sof_err = sof_err_q;

endmodule

// File: tb/tb_med_stream_3x3.sv
// Directed bench for med_stream_3x3 at 8x6 pixels, 8-bit data.
module tb_med_stream_3x3;

  localparam int WIDTH = 8;
  localparam int COLS  = 8;
  localparam int ROWS  = 6;
  localparam int NPIX  = COLS * ROWS;

  typedef logic [7:0] img_t [ROWS][COLS];
  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
  } out_t;

  logic       clk = 1'b0;
  logic       rst, s_valid, s_ready, s_sof, m_valid, m_ready, m_sof, m_eol, sof_err;
  logic [7:0] s_data, m_data;

  always #5 clk = ~clk;

  med_stream_3x3 #(.WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_sof  (s_sof),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_sof  (m_sof),
    .m_eol  (m_eol),
    .sof_err(sof_err)
  );

  int   n_vec = 0, n_err = 0;
  int   cyc_cnt = 0, sof_cnt = 0, first_v_cyc = -1, acc22_cyc = -1;
  bit   acc_now, hold_pend;
  logic [9:0] held;
  out_t out_q[$], exp_q[$];
  img_t img, img_old;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, return just after the rising edge.
  task automatic cyc();
    cyc_cnt++;
    @(negedge clk);
    if (hold_pend) begin
      chk("hold valid", 32'(m_valid), 32'd1);
      chk("hold pixel", 32'({m_data, m_sof, m_eol}), 32'(held));
    end
    hold_pend = m_valid && !m_ready;
    held      = {m_data, m_sof, m_eol};
    if (m_valid && first_v_cyc < 0) first_v_cyc = cyc_cnt;
    if (m_valid && m_ready) out_q.push_back({m_data, m_sof, m_eol});
    if (sof_err) sof_cnt++;
    acc_now = s_valid && s_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int first, input int last, input bit sof_first, input bit rnd);
    int tries;
    for (int p = first; p < last; p++) begin
      tries   = 0;
      s_valid = 1'b1;
      s_data  = img[p / COLS][p % COLS];
      s_sof   = sof_first && (p == first);
      do begin
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc();
        tries++;
      end while (!acc_now && tries < 50);
      if (!acc_now) chk("accept timeout", 32'(acc_now), 32'd1);
      if (p == 2 * COLS + 2) acc22_cyc = cyc_cnt;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic drain(input int n_exp, input bit rnd);
    int idle;
    idle    = 0;
    s_valid = 1'b0;
    for (int k = 0; k < 300 && idle < 12; k++) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      if (out_q.size() >= n_exp) idle++;
    end
    m_ready = 1'b1;
    cyc();
  endtask

  // Reference: median of each interior window reached within the first npix pixels.
  task automatic add_exp(input img_t im, input int npix);
    logic [7:0] v [9];
    logic [7:0] t;
    int r, c;
    for (int p = 0; p < npix; p++) begin
      r = p / COLS;
      c = p % COLS;
      if (r >= 2 && c >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            v[3*i+j] = im[r-2+i][c-2+j];
        for (int a = 0; a < 8; a++)
          for (int b = 0; b < 8 - a; b++)
            if (v[b] > v[b+1]) begin
              t = v[b]; v[b] = v[b+1]; v[b+1] = t;
            end
        exp_q.push_back({v[4], (r == 2 && c == 2), (c == COLS - 1)});
      end
    end
  endtask

  task automatic compare(input string tag);
    chk($sformatf("%s count", tag), 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s[%0d] pix", tag, i), 32'(out_q[i].data), 32'(exp_q[i].data));
      chk($sformatf("%s[%0d] sof/eol", tag, i), 32'({out_q[i].sof, out_q[i].eol}),
          32'({exp_q[i].sof, exp_q[i].eol}));
    end
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        img[r][c] = 8'(8 * r + c);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        img[r][c] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; m_ready = 1'b1; hold_pend = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset m_valid", 32'(m_valid), 32'd0);
    chk("reset m_data", 32'(m_data), 32'd0);
    chk("reset m_sof", 32'(m_sof), 32'd0);
    chk("reset m_eol", 32'(m_eol), 32'd0);
    chk("reset sof_err", 32'(sof_err), 32'd0);
    chk("reset s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    cyc();

    // constant frame
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        img[r][c] = 8'd100;
    add_exp(img, NPIX);
    sof_cnt = 0;
    send(0, NPIX, 1'b1, 1'b0);
    drain(24, 1'b0);
    compare("const");
    chk("const sof_err", 32'(sof_cnt), 32'd0);

    // single impulse is rejected
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        img[r][c] = 8'd0;
    img[3][3] = 8'd255;
    add_exp(img, NPIX);
    send(0, NPIX, 1'b1, 1'b0);
    drain(24, 1'b0);
    compare("impulse");

    // ramp with latency check
    fill_ramp();
    add_exp(img, NPIX);
    first_v_cyc = -1;
    acc22_cyc   = -1;
    send(0, NPIX, 1'b1, 1'b0);
    drain(24, 1'b0);
    chk("ramp latency", 32'(first_v_cyc - acc22_cyc), 32'd4);
    compare("ramp");

    // same ramp under random backpressure
    add_exp(img, NPIX);
    send(0, NPIX, 1'b1, 1'b1);
    drain(24, 1'b1);
    compare("ramp_bp");

    // random frame under random backpressure
    fill_rand();
    add_exp(img, NPIX);
    send(0, NPIX, 1'b1, 1'b1);
    drain(24, 1'b1);
    compare("rand_bp");

    // early start-of-frame at (3,4): old partial drains, new frame restarts
    fill_ramp();
    img_old = img;
    sof_cnt = 0;
    send(0, 3 * COLS + 4, 1'b1, 1'b0);
    fill_rand();
    add_exp(img_old, 3 * COLS + 4);
    add_exp(img, NPIX);
    send(0, NPIX, 1'b1, 1'b0);
    drain(32, 1'b0);
    compare("resync");
    chk("resync sof_err pulses", 32'(sof_cnt), 32'd1);

    // reset mid-frame with the next pixel at (4,5)
    fill_rand();
    send(0, 4 * COLS + 5, 1'b1, 1'b0);
    cyc();
    chk("pre-reset m_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid-reset m_valid", 32'(m_valid), 32'd0);
    chk("mid-reset m_data", 32'(m_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    hold_pend = 1'b0;
    out_q.delete();
    sof_cnt = 0;
    fill_rand();
    add_exp(img, NPIX);
    send(0, NPIX, 1'b1, 1'b0);
    drain(24, 1'b0);
    compare("post_reset");
    chk("post_reset sof_err", 32'(sof_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
